// File: rtl/gan_pkg.sv
// Shared definitions for the GAN front-end: reduction mode encodings and the
// width helpers used by the resampler and the MAC layers.
package gan_pkg;

  localparam logic [1:0] MODE_NEAREST = 2'd0;
  localparam logic [1:0] MODE_MAX     = 2'd1;
  localparam logic [1:0] MODE_SUM     = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Clamp a sign- or zero-extended value into an out_w-bit word.
  function automatic logic [63:0] saturate(input logic signed [63:0] value,
                                           input int out_w, input bit is_signed);
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    if (is_signed) begin
      hi_lim = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo_lim = -(64'sd1 <<< (out_w - 1));
    end else begin
      hi_lim = (64'sd1 <<< out_w) - 64'sd1;
      lo_lim = 64'sd0;
    end
    if (value > hi_lim) return hi_lim;
    else if (value < lo_lim) return lo_lim;
    else return value;
  endfunction

endpackage

// File: rtl/resample_window_unit.sv
// Per-word reduction datapath: seeds a window, folds further words in by the
// selected mode, and presents the (saturated) window result for emission.
module resample_window_unit
  import gan_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed,
  input  logic                  accumulate,
  input  logic                  emit,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] word_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  word_ext;
  logic [63:0]           acc_wide;
  logic [DATA_WIDTH-1:0] sat_word;
  logic                  word_gt;

  always_comb begin
    word_ext = SIGNED ? ACC_WIDTH'($signed(word_in)) : ACC_WIDTH'(word_in);
    word_gt  = SIGNED ? ($signed(word_ext) > $signed(acc_q)) : (word_ext > acc_q);
    acc_next = acc_q;
    if (seed) begin
      acc_next = word_ext;
    end else if (accumulate) begin
      case (mode)
        MODE_MAX: if (word_gt) acc_next = word_ext;
        MODE_SUM: acc_next = acc_q + word_ext;
        default:  acc_next = acc_q;
      endcase
    end
    acc_d = acc_next;
    // The result includes the current word, so single-word windows emit on their seed cycle.
    acc_wide     = SIGNED ? 64'($signed(acc_next)) : 64'(acc_next);
    sat_word     = DATA_WIDTH'(saturate(acc_wide, DATA_WIDTH, SIGNED));
    result       = (mode == MODE_SUM) ? sat_word : acc_next[DATA_WIDTH-1:0];
    result_valid = emit & (seed | accumulate);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/frame_resampler.sv
// Reduces an INPUT_COUNT-word frame to OUTPUT_COUNT words, one input word per
// clock, double-buffered so sampled_flat holds the last result while busy.
module frame_resampler
  import gan_pkg::*;
#(
  parameter int INPUT_COUNT  = 16,
  parameter int OUTPUT_COUNT = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int SIGNED       = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic [DATA_WIDTH*INPUT_COUNT-1:0]  frame_flat,
  output logic [DATA_WIDTH*OUTPUT_COUNT-1:0] sampled_flat,
  output logic                               busy,
  output logic                               done,
  output logic                               mode_err
);

  localparam int ACC_WIDTH = DATA_WIDTH + clog2(INPUT_COUNT);
  localparam int IDX_W     = clog2(INPUT_COUNT + 1);
  localparam int WIN_W     = clog2(OUTPUT_COUNT + 1);
  localparam int POS_W     = clog2((INPUT_COUNT + 2) * (OUTPUT_COUNT + 1)) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (OUTPUT_COUNT < 1 || INPUT_COUNT < OUTPUT_COUNT) begin : g_bad_params
    $error("frame_resampler: need 1 <= OUTPUT_COUNT <= INPUT_COUNT");
  end

  logic [1:0]                         state_q, state_d;
  logic [DATA_WIDTH*INPUT_COUNT-1:0]  frame_q, frame_d;
  logic [1:0]                         mode_q, mode_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [WIN_W-1:0]                   win_q, win_d;
  logic [POS_W-1:0]                   nxt_q, nxt_d;
  logic [POS_W-1:0]                   bnd_q, bnd_d;
  logic                               seed_q, seed_d;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0] sampled_q, sampled_d;
  logic                               done_q, done_d;
  logic                               mode_err_q, mode_err_d;

  logic [DATA_WIDTH-1:0] word_cur;
  logic [DATA_WIDTH-1:0] unit_result;
  logic                  unit_valid;
  logic                  in_scan;
  logic                  end_win;

  resample_window_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED != 0)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .seed        (in_scan & seed_q),
    .accumulate  (in_scan),
    .emit        (end_win),
    .mode        (mode_q),
    .word_in     (word_cur),
    .result      (unit_result),
    .result_valid(unit_valid)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    win_d      = win_q;
    nxt_d      = nxt_q;
    bnd_d      = bnd_q;
    seed_d     = seed_q;
    shadow_d   = shadow_q;
    sampled_d  = sampled_q;
    done_d     = 1'b0;
    mode_err_d = 1'b0;

    word_cur = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (idx_q == IDX_W'(i)) word_cur = frame_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Window k ends at word j when (k+1)*IN < (j+2)*OUT; nxt/bnd track both products.
    in_scan = (state_q == ST_SCAN);
    end_win = in_scan && (bnd_q < nxt_q);

    case (state_q)
      ST_SCAN: begin
        idx_d  = idx_q + IDX_W'(1);
        nxt_d  = nxt_q + POS_W'(OUTPUT_COUNT);
        seed_d = end_win;
        if (end_win) begin
          win_d = win_q + WIN_W'(1);
          bnd_d = bnd_q + POS_W'(INPUT_COUNT);
        end
        if (idx_q == IDX_W'(INPUT_COUNT - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        sampled_d  = shadow_q;
        done_d     = 1'b1;
        mode_err_d = (mode_q == MODE_RSVD);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      state_d = ST_SCAN;
      frame_d = frame_flat;
      mode_d  = mode;
      idx_d   = '0;
      win_d   = '0;
      nxt_d   = POS_W'(2 * OUTPUT_COUNT);
      bnd_d   = POS_W'(INPUT_COUNT);
      seed_d  = 1'b1;
    end

    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      if (unit_valid && win_q == WIN_W'(k)) shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = unit_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      win_q      <= '0;
      nxt_q      <= '0;
      bnd_q      <= '0;
      seed_q     <= 1'b0;
      shadow_q   <= '0;
      sampled_q  <= '0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      nxt_q      <= nxt_d;
      bnd_q      <= bnd_d;
      seed_q     <= seed_d;
      shadow_q   <= shadow_d;
      sampled_q  <= sampled_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign busy         = in_scan;
  assign done         = done_q;
  assign mode_err     = mode_err_q;
  assign sampled_flat = sampled_q;

endmodule
